// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle shift/add/logic/compare, iterative
// shift-add multiply and restoring divide, one bit per cycle.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] porta,
  input  logic [WIDTH-1:0] portb,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] porto,
  output logic [WIDTH-1:0] hi,
  output logic             n_flag,
  output logic             z_flag,
  output logic             v_flag,
  output logic             dz_flag
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam int M   = WIDTH - 1;

  localparam logic [3:0] OP_SLL  = 4'd0;
  localparam logic [3:0] OP_SRL  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MULU = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12;
  localparam logic [3:0] OP_DIV  = 4'd13;

  localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   MIN_W   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] ZERO_2W = {(2*WIDTH){1'b0}};
  localparam logic [CW-1:0]      CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      CNT_END = CW'(WIDTH);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t           state_r;
  logic [3:0]       op_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] hi_w_r;
  logic [WIDTH-1:0] lo_w_r;
  logic [WIDTH-1:0] mcand_r;
  logic             sgn_xor_r;
  logic             sgn_a_r;
  logic             div_ovf_r;

  logic [WIDTH-1:0]   sum_s, diff_s, sc_res_s, sc_hi_s;
  logic               sc_v_s, sc_dz_s, sc_flags_s;
  logic               op_sgn_s, long_s, is_div_s, is_sgn_s, last_s;
  logic [CW-1:0]      cnt_inc_s;
  logic [WIDTH:0]     mul_sum_s, rem_sh_s, div_diff_s;
  logic [WIDTH-1:0]   step_hi_s, step_lo_s, fin_hi_s, fin_lo_s;
  logic [2*WIDTH-1:0] prod_s, prod_fin_s;
  logic               fin_v_s;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    mag = (sgn && x[M]) ? (ZERO_W - x) : x;
  endfunction

  assign sum_s     = porta + portb;
  assign diff_s    = porta - portb;
  assign op_sgn_s  = (op == OP_MUL) || (op == OP_DIV);
  assign long_s    = (op == OP_MULU) || (op == OP_MUL) ||
                     (((op == OP_DIVU) || (op == OP_DIV)) && (portb != ZERO_W));
  assign is_div_s  = (op_r == OP_DIVU) || (op_r == OP_DIV);
  assign is_sgn_s  = (op_r == OP_MUL) || (op_r == OP_DIV);
  assign cnt_inc_s = cnt_r + CNT_ONE;
  assign last_s    = (cnt_inc_s == CNT_END);

  // Single-cycle results, including the divide-by-zero shortcut.
  always_comb begin
    sc_res_s   = ZERO_W;
    sc_hi_s    = ZERO_W;
    sc_v_s     = 1'b0;
    sc_dz_s    = 1'b0;
    sc_flags_s = 1'b1;
    case (op)
      OP_SLL:  sc_res_s = porta << portb[SHW-1:0];
      OP_SRL:  sc_res_s = porta >> portb[SHW-1:0];
      OP_ADD: begin
        sc_res_s = sum_s;
        sc_v_s   = (porta[M] == portb[M]) && (sum_s[M] != porta[M]);
      end
      OP_SUB: begin
        sc_res_s = diff_s;
        sc_v_s   = (porta[M] != portb[M]) && (diff_s[M] != porta[M]);
      end
      OP_AND:  sc_res_s = porta & portb;
      OP_OR:   sc_res_s = porta | portb;
      OP_XOR:  sc_res_s = porta ^ portb;
      OP_NOR:  sc_res_s = ~(porta | portb);
      OP_SLT:  sc_res_s = {{(WIDTH-1){1'b0}}, ($signed(porta) < $signed(portb))};
      OP_SLTU: sc_res_s = {{(WIDTH-1){1'b0}}, (porta < portb)};
      OP_MULU, OP_MUL: sc_res_s = ZERO_W;
      OP_DIVU, OP_DIV: begin
        sc_res_s = ONES_W;
        sc_hi_s  = porta;
        sc_dz_s  = 1'b1;
      end
      default: sc_flags_s = 1'b0;
    endcase
  end

  // One shift-add or restore-subtract step on the working registers.
  always_comb begin
    mul_sum_s  = {1'b0, hi_w_r} + (lo_w_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    rem_sh_s   = {hi_w_r, lo_w_r[M]};
    div_diff_s = rem_sh_s - {1'b0, mcand_r};
    if (is_div_s) begin
      step_hi_s = div_diff_s[WIDTH] ? rem_sh_s[WIDTH-1:0] : div_diff_s[WIDTH-1:0];
      step_lo_s = {lo_w_r[WIDTH-2:0], ~div_diff_s[WIDTH]};
    end else begin
      step_hi_s = mul_sum_s[WIDTH:1];
      step_lo_s = {mul_sum_s[0], lo_w_r[M:1]};
    end
  end

  // Sign fix-up of the final step and overflow detection.
  always_comb begin
    prod_s     = {step_hi_s, step_lo_s};
    prod_fin_s = sgn_xor_r ? (ZERO_2W - prod_s) : prod_s;
    if (is_div_s) begin
      fin_lo_s = sgn_xor_r ? (ZERO_W - step_lo_s) : step_lo_s;
      fin_hi_s = sgn_a_r ? (ZERO_W - step_hi_s) : step_hi_s;
      fin_v_s  = div_ovf_r;
    end else begin
      fin_lo_s = prod_fin_s[WIDTH-1:0];
      fin_hi_s = prod_fin_s[2*WIDTH-1:WIDTH];
      fin_v_s  = is_sgn_s ? (fin_hi_s != {WIDTH{fin_lo_s[M]}}) : (fin_hi_s != ZERO_W);
    end
  end

  // Control FSM, iteration datapath and registered results.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r   <= S_IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      porto     <= ZERO_W;
      hi        <= ZERO_W;
      n_flag    <= 1'b0;
      z_flag    <= 1'b0;
      v_flag    <= 1'b0;
      dz_flag   <= 1'b0;
      op_r      <= 4'd0;
      cnt_r     <= {CW{1'b0}};
      hi_w_r    <= ZERO_W;
      lo_w_r    <= ZERO_W;
      mcand_r   <= ZERO_W;
      sgn_xor_r <= 1'b0;
      sgn_a_r   <= 1'b0;
      div_ovf_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start && ready) begin
            op_r <= op;
            if (long_s) begin
              state_r   <= S_BUSY;
              ready     <= 1'b0;
              done      <= 1'b0;
              cnt_r     <= {CW{1'b0}};
              hi_w_r    <= ZERO_W;
              lo_w_r    <= mag(porta, op_sgn_s);
              mcand_r   <= mag(portb, op_sgn_s);
              sgn_xor_r <= op_sgn_s & (porta[M] ^ portb[M]);
              sgn_a_r   <= op_sgn_s & porta[M];
              div_ovf_r <= (op == OP_DIV) && (porta == MIN_W) && (portb == ONES_W);
            end else begin
              done    <= 1'b1;
              porto   <= sc_res_s;
              hi      <= sc_hi_s;
              n_flag  <= sc_flags_s & sc_res_s[M];
              z_flag  <= sc_flags_s & (sc_res_s == ZERO_W);
              v_flag  <= sc_v_s;
              dz_flag <= sc_dz_s;
            end
          end else begin
            done <= 1'b0;
          end
        end
        S_BUSY: begin
          hi_w_r <= step_hi_s;
          lo_w_r <= step_lo_s;
          if (last_s) begin
            state_r <= S_IDLE;
            ready   <= 1'b1;
            done    <= 1'b1;
            cnt_r   <= {CW{1'b0}};
            porto   <= fin_lo_s;
            hi      <= fin_hi_s;
            n_flag  <= fin_lo_s[M];
            z_flag  <= (fin_lo_s == ZERO_W);
            v_flag  <= fin_v_s;
            dz_flag <= 1'b0;
          end else begin
            cnt_r <= cnt_inc_s;
            done  <= 1'b0;
          end
        end
        default: begin
          state_r <= S_IDLE;
          ready   <= 1'b1;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
